// File: rtl/delay_line_mem_ctrl_if.sv
// delay_line_mem_ctrl_if: request/response bus between the test harness and the delay-line memory controller
interface delay_line_mem_ctrl_if #(
  parameter int ADDR_W    = 6,
  parameter int WORD_BITS = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [ADDR_W-1:0]    req_addr;
  logic [WORD_BITS-1:0] req_wdata;
  logic                 rsp_valid;
  logic [WORD_BITS-1:0] rsp_rdata;
  logic                 rsp_err;
  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/delay_line_mem_ctrl.sv
// delay_line_mem_ctrl: word-addressed memory built on a recirculating serial delay line
module delay_line_mem_ctrl #(
  parameter int CLK_FREQ   = 81_000_000,
  parameter int BIT_CYCLES = 154,
  parameter int LINE_BITS  = 576,
  parameter int WORD_BITS  = 16,
  parameter int ADDR_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 line_in,
  output logic                 line_out,
  output logic                 bit_tick,
  delay_line_mem_ctrl_if.slave bus
);
  localparam int WORDS = LINE_BITS / WORD_BITS;
  localparam int PH_W  = $clog2(BIT_CYCLES);
  localparam int POS_W = $clog2(LINE_BITS);
  localparam int IDX_W = $clog2(WORD_BITS);
  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  if (CLK_FREQ <= 0 || BIT_CYCLES < 2 || LINE_BITS % WORD_BITS != 0) begin : g_bad_params
    $error("delay_line_mem_ctrl: inconsistent timing or geometry parameters");
  end
  typedef enum logic [2:0] {IDLE, ERR, WAIT, XFER, CLEAR, WIPE, RESP} state_t;
  state_t               state, state_n;
  logic [PH_W-1:0]      phase;
  logic [POS_W-1:0]     pos, pos_n, base;
  logic [IDX_W-1:0]     idx;
  logic                 rx_bit, live, wrap, accept, bad, sub, zero, cap, last, nxt_bit;
  logic [1:0]           op;
  logic [ADDR_W-1:0]    addr;
  logic [WORD_BITS-1:0] wdata, rdata;
  assign wrap   = phase == PH_W'(BIT_CYCLES - 1);
  assign pos_n  = pos == POS_W'(LINE_BITS - 1) ? '0 : pos + 1'b1;
  assign base   = POS_W'(addr) * POS_W'(WORD_BITS);
  assign idx    = IDX_W'(pos_n - base);
  assign last   = idx == IDX_W'(WORD_BITS - 1);
  assign accept = bus.req_valid & bus.req_ready;
  assign bad    = bus.req_op == 2'b11 || 32'(bus.req_addr) >= 32'(WORDS);
  // pos is the position currently on line_out; pos_n is the one the coming tick drives
  always_comb begin
    state_n = state;
    sub     = 1'b0;
    case (state)
      IDLE:     if (accept) state_n = bad ? ERR : (bus.req_op == OP_CLR ? CLEAR : WAIT);
      ERR:      state_n = IDLE;
      WAIT:     if (wrap && pos_n == base) begin
                  sub     = 1'b1;
                  state_n = XFER;
                end
      XFER:     if (wrap) begin
                  sub     = 1'b1;
                  state_n = last ? RESP : XFER;
                end
      CLEAR:    if (wrap && pos_n == '0) state_n = WIPE;
      WIPE:     if (wrap && pos_n == POS_W'(LINE_BITS - 1)) state_n = RESP;
      default:  state_n = IDLE;
    endcase
  end
  assign zero    = state == WIPE || (state == CLEAR && pos_n == '0);
  assign cap     = sub && op == OP_RD;
  assign nxt_bit = zero ? 1'b0 : (sub && op == OP_WR) ? wdata[idx] : rx_bit;
  assign bus.req_ready = live && state == IDLE;
  assign bus.rsp_valid = state == ERR || state == RESP;
  assign bus.rsp_err   = state == ERR;
  assign bus.rsp_rdata = (state == RESP && op == OP_RD) ? rdata : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= '0;
      pos      <= '0;
      rx_bit   <= 1'b0;
      line_out <= 1'b0;
      bit_tick <= 1'b0;
      live     <= 1'b0;
    end else begin
      state    <= state_n;
      live     <= 1'b1;
      phase    <= wrap ? '0 : phase + 1'b1;
      bit_tick <= wrap;
      if (phase == PH_W'(BIT_CYCLES / 2)) rx_bit <= line_in;
      if (wrap) begin
        pos      <= pos_n;
        line_out <= nxt_bit;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      op    <= bus.req_op;
      addr  <= bus.req_addr;
      wdata <= bus.req_wdata;
    end
    if (cap) rdata[idx] <= rx_bit;
  end
endmodule

// File: tb/tb_delay_line_mem_ctrl.sv
// tb_delay_line_mem_ctrl: randomized bench with a word-array reference model and a shift-register delay line
module tb_delay_line_mem_ctrl;
  localparam int BC      = 4;
  localparam int LB      = 576;
  localparam int WB      = 16;
  localparam int AW      = 6;
  localparam int WORDS   = LB / WB;
  localparam int DLY     = (LB - 1) * BC;
  localparam int RW_MAX  = (LB + WB) * BC + 2;
  localparam int CLR_MAX = 2 * LB * BC + 2;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1, CL = 2'd2, RSV = 2'd3;
  logic clk = 1'b0, reset = 1'b1, line_in = 1'b0, line_out, bit_tick;
  int tests = 0, fails = 0;
  delay_line_mem_ctrl_if #(.ADDR_W(AW), .WORD_BITS(WB)) bus ();
  delay_line_mem_ctrl #(.BIT_CYCLES(BC), .LINE_BITS(LB), .WORD_BITS(WB), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .line_in(line_in), .line_out(line_out), .bit_tick(bit_tick), .bus(bus)
  );
  always #5 clk = ~clk;
  bit dl [DLY];
  int dl_i = 0;
  always @(posedge clk) begin
    line_in  <= dl[dl_i];
    dl[dl_i] <= line_out;
    dl_i     <= dl_i == DLY - 1 ? 0 : dl_i + 1;
  end
  logic [WB-1:0] mem [WORDS];
  bit known [WORDS];
  function automatic logic [WB:0] model(input logic [1:0] op, input int a, input logic [WB-1:0] d, output bit chk);
    chk = 1'b1;
    if (op == RSV || a >= WORDS) return {1'b1, {WB{1'b0}}};
    if (op == CL) begin
      foreach (mem[i]) begin
        mem[i]   = '0;
        known[i] = 1'b1;
      end
      return '0;
    end
    if (op == WR) begin
      mem[a]   = d;
      known[a] = 1'b1;
      return '0;
    end
    chk = known[a];
    return {1'b0, mem[a]};
  endfunction
  function automatic int limit(input logic [1:0] op, input bit e);
    return e ? 1 : (op == CL ? CLR_MAX : RW_MAX);
  endfunction
  task automatic do_req(input logic [1:0] op, input int a, input logic [WB-1:0] d,
                        output logic [WB-1:0] rd, output logic er, output int lat, output logic pk);
    int n = 0;
    bus.req_op = op; bus.req_addr = AW'(a); bus.req_wdata = d; bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 4 * BC) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat <= CLR_MAX) begin @(posedge clk); #1; lat++; end
    rd = bus.rsp_rdata; er = bus.rsp_err;
    @(posedge clk); #1;
    pk = bus.rsp_valid === 1'b0 && bus.req_ready === 1'b1;
  endtask
  task automatic test_reset();
    int n = 0, per = 0;
    reset = 1'b1; bus.req_valid = 1'b0;
    foreach (known[i]) known[i] = 1'b0;
    repeat (5) @(posedge clk); #1;
    tests++;
    if (line_out !== 1'b0 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0 ||
        bus.rsp_err !== 1'b0 || bit_tick !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: line_out=%b ready=%b rsp_valid=%b rdata=%h err=%b tick=%b, want all 0",
               line_out, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bit_tick);
    end
    reset = 1'b0;
    tests++;
    if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL ready_at_release: got %b want 0", bus.req_ready); end
    @(posedge clk); #1;
    tests++;
    if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL ready_after_release: got %b want 1", bus.req_ready); end
    while (bit_tick !== 1'b1 && n < 4 * BC) begin @(posedge clk); #1; n++; end
    do begin @(posedge clk); #1; per++; end while (bit_tick !== 1'b1 && per < 4 * BC);
    tests++;
    if (per != BC) begin fails++; $display("FAIL bit_tick_period: got %0d want %0d", per, BC); end
  endtask
  task automatic test_write_read();
    logic [WB-1:0] rd; logic er, pk; int lat; bit chk; logic [WB:0] ex; logic [1:0] op;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin repeat (3 * LB * BC) @(posedge clk); #1; end
      op = k == 0 ? WR : RD;
      do_req(op, 3, 16'hA5C3, rd, er, lat, pk);
      ex = model(op, 3, 16'hA5C3, chk);
      tests++;
      if (er !== ex[WB] || (chk && rd !== ex[WB-1:0]) || lat > limit(op, ex[WB]) || !pk) begin
        fails++;
        $display("FAIL write_read[%0d] op=%0d: got err=%b rdata=%h lat=%0d pulse_ok=%b; want err=%b rdata=%h lat<=%0d",
                 k, op, er, rd, lat, pk, ex[WB], ex[WB-1:0], limit(op, ex[WB]));
      end
    end
  endtask
  task automatic test_wrap();
    logic [WB-1:0] rd; logic er, pk; int lat; bit chk; logic [WB:0] ex;
    logic [1:0] ops [6] = '{WR, WR, WR, RD, RD, RD};
    int adr [6] = '{34, 0, 35, 34, 0, 35};
    logic [WB-1:0] dat [6];
    dat = '{WB'($urandom), 16'h0001, 16'h8000, 16'h0, 16'h0, 16'h0};
    for (int k = 0; k < 6; k++) begin
      do_req(ops[k], adr[k], dat[k], rd, er, lat, pk);
      ex = model(ops[k], adr[k], dat[k], chk);
      tests++;
      if (er !== ex[WB] || (chk && rd !== ex[WB-1:0]) || lat > limit(ops[k], ex[WB]) || !pk) begin
        fails++;
        $display("FAIL wrap[%0d] op=%0d addr=%0d: got err=%b rdata=%h lat=%0d pulse_ok=%b; want err=%b rdata=%h lat<=%0d",
                 k, ops[k], adr[k], er, rd, lat, pk, ex[WB], ex[WB-1:0], limit(ops[k], ex[WB]));
      end
    end
  endtask
  task automatic test_errors();
    logic [WB-1:0] rd; logic er, pk; int lat; bit chk; logic [WB:0] ex;
    logic [1:0] ops [5] = '{WR, RD, RSV, WR, RD};
    int adr [5] = '{5, 36, 5, 63, 5};
    logic [WB-1:0] d = WB'($urandom);
    for (int k = 0; k < 5; k++) begin
      do_req(ops[k], adr[k], k == 0 ? d : ~d, rd, er, lat, pk);
      ex = model(ops[k], adr[k], k == 0 ? d : ~d, chk);
      tests++;
      if (er !== ex[WB] || (chk && rd !== ex[WB-1:0]) || lat > limit(ops[k], ex[WB]) || !pk) begin
        fails++;
        $display("FAIL errors[%0d] op=%0d addr=%0d: got err=%b rdata=%h lat=%0d pulse_ok=%b; want err=%b rdata=%h lat<=%0d",
                 k, ops[k], adr[k], er, rd, lat, pk, ex[WB], ex[WB-1:0], limit(ops[k], ex[WB]));
      end
    end
  endtask
  task automatic test_clear();
    logic [WB-1:0] rd, d; logic er, pk; int lat; bit chk; logic [WB:0] ex; logic [1:0] op;
    for (int k = 0; k < 2 * WORDS + 1; k++) begin
      op = k < WORDS ? WR : (k == WORDS ? CL : RD);
      d  = WB'($urandom) | 16'h0100;
      do_req(op, k % WORDS, d, rd, er, lat, pk);
      ex = model(op, k % WORDS, d, chk);
      tests++;
      if (er !== ex[WB] || (chk && rd !== ex[WB-1:0]) || lat > limit(op, ex[WB]) || !pk) begin
        fails++;
        $display("FAIL clear[%0d] op=%0d addr=%0d: got err=%b rdata=%h lat=%0d pulse_ok=%b; want err=%b rdata=%h lat<=%0d",
                 k, op, k % WORDS, er, rd, lat, pk, ex[WB], ex[WB-1:0], limit(op, ex[WB]));
      end
    end
  endtask
  task automatic test_random();
    logic [WB-1:0] rd, d; logic er, pk; int lat, a; bit chk; logic [WB:0] ex; logic [1:0] op;
    for (int k = 0; k < 10; k++) begin
      op = $urandom_range(0, 1) == 0 ? RD : WR;
      a  = $urandom_range(0, WORDS - 1);
      d  = WB'($urandom);
      do_req(op, a, d, rd, er, lat, pk);
      ex = model(op, a, d, chk);
      tests++;
      if (er !== ex[WB] || (chk && rd !== ex[WB-1:0]) || lat > limit(op, ex[WB]) || !pk) begin
        fails++;
        $display("FAIL random[%0d] op=%0d addr=%0d: got err=%b rdata=%h lat=%0d pulse_ok=%b; want err=%b rdata=%h lat<=%0d",
                 k, op, a, er, rd, lat, pk, ex[WB], ex[WB-1:0], limit(op, ex[WB]));
      end
    end
  endtask
  task automatic test_reset_mid_xfer();
    logic [WB-1:0] rd, d; logic er, pk, seen = 1'b0, lo = 1'b0; int lat; bit chk; logic [WB:0] ex; logic [1:0] op;
    do_req(WR, 3, WB'($urandom), rd, er, lat, pk);
    bus.req_op = WR; bus.req_addr = AW'(4); bus.req_wdata = WB'($urandom); bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (8 * BC) begin seen |= bus.rsp_valid; @(posedge clk); #1; end
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; seen |= bus.rsp_valid; lo |= line_out; end
    reset = 1'b0;
    foreach (known[i]) known[i] = 1'b0;
    repeat (2 * BC) begin @(posedge clk); #1; seen |= bus.rsp_valid; end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_rsp: rsp_valid seen=%b want 0", seen); end
    tests++;
    if (lo !== 1'b0) begin fails++; $display("FAIL abort_line_out: line_out during reset=%b want 0", lo); end
    tests++;
    if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b want 1", bus.req_ready); end
    d = WB'($urandom);
    for (int k = 0; k < 2; k++) begin
      op = k == 0 ? WR : RD;
      do_req(op, 4, d, rd, er, lat, pk);
      ex = model(op, 4, d, chk);
      tests++;
      if (er !== ex[WB] || (chk && rd !== ex[WB-1:0]) || lat > limit(op, ex[WB]) || !pk) begin
        fails++;
        $display("FAIL after_abort[%0d] op=%0d: got err=%b rdata=%h lat=%0d pulse_ok=%b; want err=%b rdata=%h lat<=%0d",
                 k, op, er, rd, lat, pk, ex[WB], ex[WB-1:0], limit(op, ex[WB]));
      end
    end
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_write_read();
    test_wrap();
    test_errors();
    test_clear();
    test_random();
    test_reset_mid_xfer();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached after %0d tests", tests);
    $fatal(1);
  end
endmodule
